// File: rtl/opamp_sar_adc_ctrl_pkg.sv
// Shared types and helpers for the opamp gain-stage SAR ADC controller.
package opamp_adc_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        SETTLE = 2'd2,
        DECIDE = 2'd3
    } adc_state_e;

    // Width of a down-counter that must hold the larger of the two phase lengths.
    function automatic int cnt_width(input int sample_cycles, input int settle_cycles);
        int max_v;
        int w;
        max_v = (sample_cycles > settle_cycles) ? sample_cycles : settle_cycles;
        w     = $clog2(max_v + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sar_result_buffer.sv
// One-entry valid/ready holding register for finished conversion codes.
// A load into an occupied, unaccepted entry replaces it and flags an overrun.
module sar_result_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_s;
    logic             valid_r;
    logic             valid_s;
    logic             overrun_r;
    logic             overrun_s;

    // Next-state: a load always wins; otherwise a handshake empties the entry.
    always_comb begin
        data_s    = data_r;
        valid_s   = valid_r;
        overrun_s = 1'b0;
        if (load_i) begin
            data_s    = data_i;
            valid_s   = 1'b1;
            overrun_s = valid_r && !ready_i;
        end else if (valid_r && ready_i) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end
    end

    // Entry, valid flag and overrun pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r    <= {WIDTH{1'b0}};
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            data_r    <= data_s;
            valid_r   <= valid_s;
            overrun_r <= overrun_s;
        end
    end

    assign data_o    = data_r;
    assign valid_o   = valid_r;
    assign overrun_o = overrun_r;

endmodule

// File: rtl/opamp_sar_adc_ctrl.sv
// Successive-approximation controller for the opamp gain-stage output node.
// Tracks the node, then binary-searches the reference DAC one bit at a time
// using the comparator decision, and hands the code to a one-entry buffer.
module opamp_sar_adc_ctrl
    import opamp_adc_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             comp_i,
    output logic             sample_o,
    output logic [WIDTH-1:0] dac_code_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] result_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             overrun_o
);

    localparam int CW = cnt_width(SAMPLE_CYCLES, SETTLE_CYCLES);
    localparam int BW = $clog2(WIDTH);

    localparam logic [CW-1:0]    CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE     = CW'(1'b1);
    localparam logic [CW-1:0]    SAMPLE_LOAD = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0]    SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : {CW{1'b0}};
    localparam logic [BW-1:0]    BIT_ZERO    = {BW{1'b0}};
    localparam logic [BW-1:0]    BIT_ONE     = BW'(1'b1);
    localparam logic [BW-1:0]    MSB_IDX     = BW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] CODE_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CODE_ONE    = WIDTH'(1'b1);
    localparam logic [WIDTH-1:0] CODE_MSB    = {1'b1, {(WIDTH-1){1'b0}}};
    // With no settle time each bit goes straight to its decision cycle.
    localparam adc_state_e       BIT_STATE   = (SETTLE_CYCLES > 0) ? SETTLE : DECIDE;

    adc_state_e       state_r;
    adc_state_e       state_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;
    logic [BW-1:0]    bit_r;
    logic [BW-1:0]    bit_s;
    logic [BW-1:0]    next_bit_s;
    logic [WIDTH-1:0] code_r;
    logic [WIDTH-1:0] code_s;
    logic [WIDTH-1:0] decided_s;
    logic [WIDTH-1:0] dac_r;
    logic [WIDTH-1:0] dac_s;
    logic             sample_r;
    logic             sample_s;
    logic             busy_r;
    logic             busy_s;
    logic             load_r;
    logic             load_s;

    // FSM next-state and registered-output next values.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        bit_s      = bit_r;
        code_s     = code_r;
        dac_s      = dac_r;
        sample_s   = sample_r;
        load_s     = 1'b0;
        next_bit_s = bit_r - BIT_ONE;
        // Comparator high means the held input sits above the trial level: keep the bit.
        if (comp_i) begin
            decided_s = dac_r;
        end else begin
            decided_s = dac_r & ~(CODE_ONE << bit_r);
        end
        // Busy spans acceptance until the finished code lands in the buffer.
        if (load_r) begin
            busy_s = 1'b0;
        end else begin
            busy_s = busy_r;
        end

        case (state_r)
            IDLE: begin
                if (start_i && !busy_r) begin
                    state_s  = SAMPLE;
                    cnt_s    = SAMPLE_LOAD;
                    bit_s    = MSB_IDX;
                    code_s   = CODE_ZERO;
                    dac_s    = CODE_ZERO;
                    sample_s = 1'b1;
                    busy_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SAMPLE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s  = BIT_STATE;
                    cnt_s    = SETTLE_LOAD;
                    bit_s    = MSB_IDX;
                    dac_s    = CODE_MSB;
                    sample_s = 1'b0;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            SETTLE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = DECIDE;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            DECIDE: begin
                code_s = decided_s;
                if (bit_r == BIT_ZERO) begin
                    state_s = IDLE;
                    dac_s   = CODE_ZERO;
                    load_s  = 1'b1;
                end else begin
                    state_s = BIT_STATE;
                    cnt_s   = SETTLE_LOAD;
                    bit_s   = next_bit_s;
                    dac_s   = decided_s | (CODE_ONE << next_bit_s);
                end
            end
            default: begin
                state_s  = IDLE;
                dac_s    = CODE_ZERO;
                sample_s = 1'b0;
                busy_s   = 1'b0;
            end
        endcase
    end

    // State, counters, code and output registers; reset aborts any conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            bit_r    <= MSB_IDX;
            code_r   <= CODE_ZERO;
            dac_r    <= CODE_ZERO;
            sample_r <= 1'b0;
            busy_r   <= 1'b0;
            load_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            bit_r    <= bit_s;
            code_r   <= code_s;
            dac_r    <= dac_s;
            sample_r <= sample_s;
            busy_r   <= busy_s;
            load_r   <= load_s;
        end
    end

    sar_result_buffer #(
        .WIDTH (WIDTH)
    ) u_result_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load_r),
        .data_i    (code_r),
        .ready_i   (ready_i),
        .data_o    (result_o),
        .valid_o   (valid_o),
        .overrun_o (overrun_o)
    );

    assign sample_o   = sample_r;
    assign dac_code_o = dac_r;
    assign busy_o     = busy_r;

endmodule

// File: tb/tb_opamp_sar_adc_ctrl.sv
// Directed + randomized bench for opamp_sar_adc_ctrl with an ideal comparator
// model; the analogue node is taken as vin + 1/2 LSB so a code equal to vin is kept.
module tb_opamp_sar_adc_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic       comp_i;
    logic       sample_o;
    logic [7:0] dac_code_o;
    logic       busy_o;
    logic [7:0] result_o;
    logic       valid_o;
    logic       ready_i;
    logic       overrun_o;
    logic [7:0] vin;

    int n_vec;
    int n_err;

    opamp_sar_adc_ctrl #(
        .WIDTH         (8),
        .SAMPLE_CYCLES (4),
        .SETTLE_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .comp_i     (comp_i),
        .sample_o   (sample_o),
        .dac_code_o (dac_code_o),
        .busy_o     (busy_o),
        .result_o   (result_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .overrun_o  (overrun_o)
    );

    // Ideal comparator: (vin + 0.5) > dac, evaluated in half-LSB units.
    assign comp_i = ({vin, 1'b1} > {dac_code_o, 1'b0});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One conversion from a start pulse; checks latency, code, track time and trial sequence.
    task automatic convert(input logic [7:0] v, input bit exp_ovr, input bit ready_at_load, input bit jitter);
        logic [7:0] exp_trials[$];
        logic [7:0] trials[$];
        logic [7:0] code;
        logic [7:0] t;
        logic [7:0] last;
        int         lat;
        int         samp;
        code = 8'h00;
        for (int k = 7; k >= 0; k--) begin
            t = code | (8'd1 << k);
            exp_trials.push_back(t);
            if (v >= t) code = t;
        end
        vin     = v;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("busy_at_start", busy_o, 1);
        chk("sample_at_start", sample_o, 1);
        samp = sample_o ? 1 : 0;
        last = 8'h00;
        lat  = 0;
        while (busy_o && lat < 40) begin
            if (jitter) start_i = 1'($urandom_range(0, 1));
            if (ready_at_load && lat == 20) ready_i = 1'b1;
            step();
            lat++;
            if (sample_o) samp++;
            if (dac_code_o != 8'h00 && dac_code_o != last) begin
                trials.push_back(dac_code_o);
                last = dac_code_o;
            end
        end
        start_i = 1'b0;
        chk("latency", lat, 21);
        chk("valid_on_done", valid_o, 1);
        chk("result", result_o, v);
        chk("overrun_on_load", overrun_o, exp_ovr);
        chk("sample_cycles", samp, 4);
        chk("trial_count", trials.size(), 8);
        if (trials.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("trial_code", trials[i], exp_trials[i]);
        end
        if (ready_at_load) ready_i = 1'b0;
    endtask

    initial begin
        logic [7:0] v1;
        logic [7:0] v2;
        int         rises[$];
        int         done;
        logic       prev;
        logic       bad;
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        start_i = 1'b0;
        ready_i = 1'b0;
        vin     = 8'h00;
        repeat (3) step();

        // Reset state.
        chk("rst_sample", sample_o, 0);
        chk("rst_dac", dac_code_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_overrun", overrun_o, 0);
        rst_n = 1'b1;
        step();

        // Reference example, then consume it.
        convert(8'hA5, 1'b0, 1'b0, 1'b0);
        step();
        chk("hold_result", result_o, 8'hA5);
        chk("hold_valid", valid_o, 1);
        ready_i = 1'b1;
        step();
        chk("consumed_valid", valid_o, 0);

        // Full-scale ends.
        convert(8'hFF, 1'b0, 1'b0, 1'b0);
        convert(8'h00, 1'b0, 1'b0, 1'b0);
        step();

        // Back-to-back with no consumer: second load overruns.
        ready_i = 1'b0;
        v1 = 8'($urandom_range(0, 255));
        v2 = 8'($urandom_range(0, 255));
        convert(v1, 1'b0, 1'b0, 1'b0);
        convert(v2, 1'b1, 1'b0, 1'b0);
        step();
        chk("overrun_one_cycle", overrun_o, 0);
        chk("overrun_keeps_second", result_o, v2);
        chk("overrun_valid", valid_o, 1);

        // Consumer accepts in the same cycle as the next load: no overrun.
        v1 = 8'($urandom_range(0, 255));
        convert(v1, 1'b0, 1'b1, 1'b0);
        step();
        chk("same_cycle_overrun", overrun_o, 0);
        chk("same_cycle_valid", valid_o, 1);
        chk("same_cycle_result", result_o, v1);
        ready_i = 1'b1;
        step();
        chk("same_cycle_drain", valid_o, 0);

        // Start held high: a conversion every 22 cycles.
        vin     = 8'($urandom_range(0, 255));
        start_i = 1'b1;
        prev    = busy_o;
        done    = 0;
        for (int e = 0; e < 120 && done < 3; e++) begin
            step();
            if (busy_o && !prev) rises.push_back(e);
            if (!busy_o && prev) begin
                chk("held_result", result_o, vin);
                done++;
                vin = 8'($urandom_range(0, 255));
            end
            prev = busy_o;
        end
        start_i = 1'b0;
        chk("held_done", done, 3);
        chk("held_rises", rises.size(), 3);
        if (rises.size() >= 3) begin
            chk("held_period_a", rises[1] - rises[0], 22);
            chk("held_period_b", rises[2] - rises[1], 22);
        end
        repeat (2) step();

        // Random codes with stray start pulses while busy.
        for (int i = 0; i < 12; i++) begin
            convert(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1);
            step();
        end

        // Asynchronous abort in the middle of a conversion, with an old result pending.
        ready_i = 1'b0;
        convert(8'h3C, 1'b0, 1'b0, 1'b0);
        vin     = 8'hC3;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (10) step();
        chk("pre_abort_busy", busy_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_sample", sample_o, 0);
        chk("abort_dac", dac_code_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_valid", valid_o, 0);
        chk("abort_result", result_o, 0);
        chk("abort_overrun", overrun_o, 0);
        step();
        rst_n = 1'b1;
        bad   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (valid_o || busy_o) bad = 1'b1;
        end
        chk("abort_quiet", bad, 0);
        convert(8'h5A, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Runaway guard.
    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
